// File: rtl/gold_router_pe_port_pkg.sv
// gold_ring PE port: shared types and packet field layout.
// Imported by the interface, the VC buffer and the port top.
package gold_router_pe_port_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 16;

    // VC phase / virtual channel
    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } vc_e;

    // ring direction
    typedef enum logic {
        CW  = 1'b0,
        CCW = 1'b1
    } dir_e;

    // packet field positions for the default width
    localparam int VC_BIT  = DEF_DATA_W - 1;
    localparam int DIR_BIT = DEF_DATA_W - 2;
    localparam int HOP_HI  = 55;
    localparam int HOP_LO  = 48;
    localparam int SRC_HI  = 47;
    localparam int SRC_LO  = 32;
    localparam int DST_HI  = 31;
    localparam int DST_LO  = 0;

endpackage

// File: rtl/gold_router_pe_port_if.sv
// gold_ring PE port: PE-link, router-core and status bundle.
// master = port side, slave = PE/core/environment side.
interface gold_router_pe_port_if
    import gold_router_pe_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              polarity;
    logic              pesi;
    logic              peri;
    logic [DATA_W-1:0] pedi;
    logic              peso;
    logic              pero;
    logic [DATA_W-1:0] pedo;
    logic              inj_valid;
    logic              inj_ready;
    logic [DATA_W-1:0] inj_data;
    logic              ej_valid;
    logic              ej_ready;
    logic [DATA_W-1:0] ej_data;
    logic              proto_err;
    logic [CNT_W-1:0]  inj_cnt;
    logic [CNT_W-1:0]  ej_cnt;

    modport master (
        output polarity,
        output peri,
        output peso,
        output pedo,
        output inj_valid,
        output inj_data,
        output ej_ready,
        output proto_err,
        output inj_cnt,
        output ej_cnt,
        input  pesi,
        input  pedi,
        input  pero,
        input  inj_ready,
        input  ej_valid,
        input  ej_data
    );

    modport slave (
        input  polarity,
        input  peri,
        input  peso,
        input  pedo,
        input  inj_valid,
        input  inj_data,
        input  ej_ready,
        input  proto_err,
        input  inj_cnt,
        input  ej_cnt,
        output pesi,
        output pedi,
        output pero,
        output inj_ready,
        output ej_valid,
        output ej_data
    );

endinterface

// File: rtl/gold_router_pe_port_vc_buf.sv
// gold_ring PE port: two-entry buffer indexed by VC.
// A write and a clear to the same VC in one cycle leave it full.
module gold_router_pe_port_vc_buf
    import gold_router_pe_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_vc,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_en,
    input  logic              clr_vc,
    input  logic              rd_vc,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        full
);

    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic [DATA_W-1:0] mem_q [2];

    // next occupancy: clear first, then set on write
    always_comb begin
        full_d = full_q;
        if (clr_en) begin
            full_d[clr_vc] = 1'b0;
        end
        if (wr_en) begin
            full_d[wr_vc] = 1'b1;
        end
    end

    // occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // payload storage, wiped on reset so nothing stale survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (wr_en) begin
            mem_q[wr_vc] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_vc];
    assign full    = full_q;

endmodule

// File: rtl/gold_router_pe_port.sv
// gold_ring PE port: router-side endpoint of the PE link.
// Owns node polarity, per-VC inject/eject buffers and statistics.
module gold_router_pe_port
    import gold_router_pe_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    gold_router_pe_port_if.master bus
);

    localparam int               PKT_VC  = DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    vc_e               pol_q;
    vc_e               pol_d;
    logic              pol;
    logic              npol;

    logic [1:0]        in_full;
    logic [DATA_W-1:0] in_rd;
    logic [1:0]        out_full;
    logic [DATA_W-1:0] out_rd;

    logic              inj_vc;
    logic              inj_cap;
    logic              inj_drop;
    logic              inj_fire;
    logic              ej_vc;
    logic              ej_cap;
    logic              ej_bad;
    logic              ej_drain;

    logic              peso_q;
    logic              peso_d;
    logic [DATA_W-1:0] pedo_q;
    logic [DATA_W-1:0] pedo_d;
    logic              err_q;
    logic              err_d;
    logic [CNT_W-1:0]  icnt_q;
    logic [CNT_W-1:0]  icnt_d;
    logic [CNT_W-1:0]  ecnt_q;
    logic [CNT_W-1:0]  ecnt_d;

    assign pol  = pol_q;
    assign npol = ~pol;

    // phase alternates every cycle out of reset
    always_comb begin
        pol_d = (pol_q == EVEN) ? ODD : EVEN;
    end

    // phase register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q <= EVEN;
        end else begin
            pol_q <= pol_d;
        end
    end

    // handshake qualifiers; PE writes next phase, core reads this phase
    always_comb begin
        inj_vc   = bus.pedi[PKT_VC];
        ej_vc    = bus.ej_data[PKT_VC];
        inj_cap  = 1'b0;
        inj_drop = 1'b0;
        if (bus.pesi) begin
            if (inj_vc == npol && !in_full[npol]) begin
                inj_cap = 1'b1;
            end else begin
                inj_drop = 1'b1;
            end
        end
        inj_fire = in_full[pol] & bus.inj_ready;
        ej_bad   = bus.ej_valid & (ej_vc != pol);
        ej_cap   = bus.ej_valid & ~out_full[pol] & (ej_vc == pol);
        ej_drain = bus.pero & out_full[npol];
    end

    gold_router_pe_port_vc_buf #(
        .DATA_W (DATA_W)
    ) u_inj_buf (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (inj_cap),
        .wr_vc   (npol),
        .wr_data (bus.pedi),
        .clr_en  (inj_fire),
        .clr_vc  (pol),
        .rd_vc   (pol),
        .rd_data (in_rd),
        .full    (in_full)
    );

    gold_router_pe_port_vc_buf #(
        .DATA_W (DATA_W)
    ) u_ej_buf (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (ej_cap),
        .wr_vc   (pol),
        .wr_data (bus.ej_data),
        .clr_en  (ej_drain),
        .clr_vc  (npol),
        .rd_vc   (npol),
        .rd_data (out_rd),
        .full    (out_full)
    );

    // delivery pulse, sticky error and saturating counters
    always_comb begin
        peso_d = 1'b0;
        pedo_d = '0;
        err_d  = err_q | inj_drop | ej_bad;
        icnt_d = icnt_q;
        ecnt_d = ecnt_q;
        if (ej_drain) begin
            peso_d = 1'b1;
            pedo_d = out_rd;
        end
        if (inj_cap && icnt_q != CNT_MAX) begin
            icnt_d = icnt_q + 1'b1;
        end
        if (ej_drain && ecnt_q != CNT_MAX) begin
            ecnt_d = ecnt_q + 1'b1;
        end
    end

    // registered PE-side outputs and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peso_q <= 1'b0;
            pedo_q <= '0;
            err_q  <= 1'b0;
            icnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            peso_q <= peso_d;
            pedo_q <= pedo_d;
            err_q  <= err_d;
            icnt_q <= icnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign bus.polarity  = pol;
    assign bus.peri      = ~in_full[npol];
    assign bus.inj_valid = in_full[pol];
    assign bus.inj_data  = in_full[pol] ? in_rd : '0;
    assign bus.ej_ready  = ~out_full[pol];
    assign bus.peso      = peso_q;
    assign bus.pedo      = pedo_q;
    assign bus.proto_err = err_q;
    assign bus.inj_cnt   = icnt_q;
    assign bus.ej_cnt    = ecnt_q;

endmodule

// File: tb/tb_gold_router_pe_port.sv
// gold_ring PE port bench: per-VC slot model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gold_router_pe_port;
    import gold_router_pe_port_pkg::*;

    localparam int DW = 64;
    localparam int CW = 4;

    localparam logic [DW-1:0] PKT2  = 64'h0001_0001_0000_0000;
    localparam logic [DW-1:0] PKT3  = 64'h0002_0002_0000_0007;
    localparam logic [DW-1:0] PKTO  = 64'h8003_0005_0000_0009;
    localparam logic [DW-1:0] E0    = 64'h0000_0000_0000_0001;
    localparam logic [DW-1:0] E1    = 64'h8000_0000_0000_0002;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    gold_router_pe_port_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    gold_router_pe_port #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // model: one optional packet slot per VC per direction
    logic          mpol   = 1'b0;
    logic [1:0]    in_v   = 2'b00;
    logic [1:0]    out_v  = 2'b00;
    logic [DW-1:0] in_d  [2];
    logic [DW-1:0] out_d [2];
    logic          mpeso  = 1'b0;
    logic [DW-1:0] mpedo  = '0;
    logic          merr   = 1'b0;
    logic [CW-1:0] mic    = '0;
    logic [CW-1:0] mec    = '0;
    logic          mp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mpol  = 1'b0;
            in_v  = 2'b00;
            out_v = 2'b00;
            mpeso = 1'b0;
            mpedo = '0;
            merr  = 1'b0;
            mic   = '0;
            mec   = '0;
        end else begin
            mp = mpol;
            if (in_v[mp] && bus.inj_ready) in_v[mp] = 1'b0;
            if (bus.pesi) begin
                if (bus.pedi[DW-1] == !mp && !in_v[!mp]) begin
                    in_v[!mp] = 1'b1;
                    in_d[!mp] = bus.pedi;
                    if (mic != '1) mic = mic + 1'b1;
                end else begin
                    merr = 1'b1;
                end
            end
            if (bus.ej_valid) begin
                if (bus.ej_data[DW-1] == mp) begin
                    if (!out_v[mp]) begin
                        out_v[mp] = 1'b1;
                        out_d[mp] = bus.ej_data;
                    end
                end else begin
                    merr = 1'b1;
                end
            end
            if (bus.pero && out_v[!mp]) begin
                mpeso      = 1'b1;
                mpedo      = out_d[!mp];
                out_v[!mp] = 1'b0;
                if (mec != '1) mec = mec + 1'b1;
            end else begin
                mpeso = 1'b0;
                mpedo = '0;
            end
            mpol = !mp;
        end
    end

    int            npulse = 0;
    int            cyc    = 0;
    logic [DW-1:0] got_q [$];
    int            pcyc_q [$];

    // per-cycle compare against the model
    always @(negedge clk) begin
        cyc++;
        chk("polarity", DW'(bus.polarity), DW'(mpol));
        chk("peri", DW'(bus.peri), DW'(!in_v[!mpol]));
        chk("inj_valid", DW'(bus.inj_valid), DW'(in_v[mpol]));
        chk("inj_data", bus.inj_data, in_v[mpol] ? in_d[mpol] : '0);
        chk("ej_ready", DW'(bus.ej_ready), DW'(!out_v[mpol]));
        chk("peso", DW'(bus.peso), DW'(mpeso));
        chk("pedo", bus.pedo, mpedo);
        chk("proto_err", DW'(bus.proto_err), DW'(merr));
        chk("inj_cnt", DW'(bus.inj_cnt), DW'(mic));
        chk("ej_cnt", DW'(bus.ej_cnt), DW'(mec));
        if (bus.peso) begin
            npulse++;
            got_q.push_back(bus.pedo);
            pcyc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pol(input logic v);
        for (int i = 0; i < 4 && mpol != v; i++) step();
    endtask

    int b;
    int base;
    int sent;
    logic rdy;

    initial begin
        bus.pesi      = 1'b0;
        bus.pedi      = '0;
        bus.pero      = 1'b0;
        bus.inj_ready = 1'b0;
        bus.ej_valid  = 1'b0;
        bus.ej_data   = '0;

        // reset and polarity toggling
        repeat (2) step();
        reset = 1'b1;
        chk("t1_pol0", DW'(bus.polarity), DW'(0));
        step();
        chk("t1_pol1", DW'(bus.polarity), DW'(1));
        step();
        chk("t1_pol2", DW'(bus.polarity), DW'(0));
        chk("t1_peri", DW'(bus.peri), DW'(1));
        chk("t1_peso", DW'(bus.peso), DW'(0));
        chk("t1_icnt", DW'(bus.inj_cnt), DW'(0));
        chk("t1_ecnt", DW'(bus.ej_cnt), DW'(0));

        // EVEN injection at polarity 1
        wait_pol(1'b1);
        bus.pesi = 1'b1;
        bus.pedi = PKT2;
        step();
        bus.pesi = 1'b0;
        chk("t2_valid", DW'(bus.inj_valid), DW'(1));
        chk("t2_data", bus.inj_data, PKT2);
        chk("t2_icnt", DW'(bus.inj_cnt), DW'(1));

        // core stalls; second EVEN send overruns
        for (int i = 0; i < 4; i++) begin
            step();
            if (mpol == 1'b1) chk("t3_peri", DW'(bus.peri), DW'(0));
        end
        wait_pol(1'b1);
        bus.pesi = 1'b1;
        bus.pedi = PKT3;
        step();
        bus.pesi = 1'b0;
        chk("t3_err", DW'(bus.proto_err), DW'(1));
        chk("t3_keep", bus.inj_data, PKT2);
        chk("t3_icnt", DW'(bus.inj_cnt), DW'(1));
        bus.inj_ready = 1'b1;
        step();
        bus.inj_ready = 1'b0;
        step();
        chk("t3_drained", DW'(bus.inj_valid), DW'(0));

        // ODD injection
        wait_pol(1'b0);
        bus.pesi = 1'b1;
        bus.pedi = PKTO;
        step();
        bus.pesi = 1'b0;
        chk("t3_odd", bus.inj_data, PKTO);
        bus.inj_ready = 1'b1;
        step();
        bus.inj_ready = 1'b0;

        // back-to-back ejection EVEN then ODD
        b = got_q.size();
        bus.pero = 1'b1;
        wait_pol(1'b0);
        bus.ej_valid = 1'b1;
        bus.ej_data  = E0;
        step();
        bus.ej_data  = E1;
        step();
        bus.ej_valid = 1'b0;
        repeat (3) step();
        chk("t4_npkt", DW'(got_q.size() - b), DW'(2));
        if (got_q.size() >= b + 2) begin
            chk("t4_first", got_q[b], E0);
            chk("t4_second", got_q[b+1], E1);
            chk("t4_b2b", DW'(pcyc_q[b+1] - pcyc_q[b]), DW'(1));
        end
        chk("t4_ecnt", DW'(bus.ej_cnt), DW'(2));

        // backpressure: three offers with PE not ready
        bus.pero = 1'b0;
        base = npulse;
        sent = 0;
        for (int i = 0; i < 40 && sent < 3; i++) begin
            if (i == 6) begin
                chk("t5_held", DW'(sent), DW'(2));
                chk("t5_nordy", DW'(bus.ej_ready), DW'(0));
                chk("t5_nopulse", DW'(npulse - base), DW'(0));
                bus.pero = 1'b1;
            end
            bus.ej_valid = 1'b1;
            bus.ej_data  = {mpol, 63'(256 + sent)};
            rdy = bus.ej_ready;
            step();
            if (rdy) sent++;
        end
        bus.ej_valid = 1'b0;
        chk("t5_sent", DW'(sent), DW'(3));
        repeat (6) step();
        chk("t5_pulses", DW'(npulse - base), DW'(3));
        chk("t5_ecnt", DW'(bus.ej_cnt), DW'(5));

        // inject counter saturation
        bus.inj_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.pesi = 1'b1;
            bus.pedi = {~mpol, 63'(i)};
            step();
        end
        bus.pesi = 1'b0;
        step();
        bus.inj_ready = 1'b0;
        chk("sat_icnt", DW'(bus.inj_cnt), DW'(15));

        // reset with every buffer full
        bus.pero = 1'b0;
        wait_pol(1'b0);
        bus.pesi     = 1'b1;
        bus.pedi     = {1'b1, 63'h11};
        bus.ej_valid = 1'b1;
        bus.ej_data  = {1'b0, 63'h22};
        step();
        bus.pedi     = {1'b0, 63'h33};
        bus.ej_data  = {1'b1, 63'h44};
        step();
        bus.pesi     = 1'b0;
        bus.ej_valid = 1'b0;
        chk("t6_full", DW'(bus.inj_valid), DW'(1));
        bus.pero      = 1'b1;
        bus.inj_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("t6_inj_valid", DW'(bus.inj_valid), DW'(0));
        chk("t6_peso", DW'(bus.peso), DW'(0));
        chk("t6_ej_ready", DW'(bus.ej_ready), DW'(1));
        step();
        step();
        reset = 1'b1;
        base = npulse;
        repeat (6) step();
        chk("t6_nostale", DW'(npulse - base), DW'(0));
        chk("t6_err", DW'(bus.proto_err), DW'(0));

        // ejection VC mismatch
        wait_pol(1'b0);
        bus.ej_valid = 1'b1;
        bus.ej_data  = {1'b1, 63'h5};
        step();
        bus.ej_valid = 1'b0;
        chk("ejbad_err", DW'(bus.proto_err), DW'(1));
        repeat (3) step();
        chk("ejbad_nopulse", DW'(npulse - base), DW'(0));
        chk("ejbad_ecnt", DW'(bus.ej_cnt), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
